fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of decode and immediate generation.
- Holds the PC and issues word requests to instruction memory.
- Buffers returned instructions in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Pre-decodes the 2-bit immediate-format select consumed by the immediate generator.
- Handles redirects (branch/jump) by flushing queued and in-flight instructions.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: immediate-format selects, the opcodes
// fetch pre-decodes, the NOP bubble, and the {pc, inst} queue entry type.
package cpu_pkg;

  localparam logic [1:0]  IMM_I_TYPE = 2'b00;
  localparam logic [1:0]  IMM_S_TYPE = 2'b01;
  localparam logic [1:0]  IMM_B_TYPE = 2'b10;

  localparam logic [6:0]  OP_STORE   = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH  = 7'b1100011;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Immediate format the generator needs; everything not S or B uses I.
  function automatic logic [1:0] imm_sel_f(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:  imm_sel_f = IMM_S_TYPE;
      OP_BRANCH: imm_sel_f = IMM_B_TYPE;
      default:   imm_sel_f = IMM_I_TYPE;
    endcase
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry queue of {pc, inst} between instruction memory and decode.
// Ports: i_push/i_data write the tail, i_pop drops the head (o_head),
// i_clear empties it (wins over push/pop); o_full, o_empty, o_count.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_clear,
  input  fetch_entry_t       i_data,
  output fetch_entry_t       o_head,
  output logic               o_full,
  output logic               o_empty,
  output logic [CNT_W-1:0]   o_count
);

  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   w_push, w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == DEPTH_C);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push  = i_push & ~i_clear;
  assign w_pop   = i_pop & ~i_clear & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Payload needs no reset: r_count gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word requests, queues returned
// instructions with their PC and hands them to decode, pre-decoding the
// immediate-format select. Redirects flush queued work and discard the
// responses still in flight.
// Ports: i_clk/i_rst_n; o_imem_req/o_imem_addr/i_imem_gnt request side;
// i_imem_rvalid/i_imem_rdata in-order responses; i_redirect/i_redirect_pc
// from execute; o_inst_valid/i_dec_ready/o_inst/o_pc/o_imm_sel to decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  input  logic        i_dec_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [1:0]  o_imm_sel
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);

  logic [31:0]       r_pc;
  logic [CNT_W-1:0]  r_out;     // requests granted, response not yet seen
  logic [CNT_W-1:0]  r_drop;    // stale responses still to be discarded
  logic [31:0]       r_ifpc [DEPTH];
  logic [PTR_W-1:0]  r_if_wr, r_if_rd;

  fetch_entry_t      w_head, w_push_data;
  logic              w_full, w_empty, w_pop, w_push, w_fire;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_used;

  assign o_inst_valid = ~w_empty & ~i_redirect;
  assign w_pop        = o_inst_valid & i_dec_ready;

  // Slots are counted after this cycle's pop so a slot drained by decode can
  // be re-requested in the same cycle; that is what sustains 1 inst/cycle.
  assign w_used      = {1'b0, r_out} + {1'b0, w_count} - {{CNT_W{1'b0}}, w_pop};
  // Gated by reset so the request drops the instant reset asserts.
  assign o_imem_req  = i_rst_n & ~i_redirect & (w_used < DEPTH_C);
  assign o_imem_addr = r_pc;
  assign w_fire      = o_imem_req & i_imem_gnt;

  assign w_push      = i_imem_rvalid & ~i_redirect & (r_drop == '0);
  assign w_push_data = '{pc: r_ifpc[r_if_rd], inst: i_imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (i_redirect),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // When empty, o_pc shows the next fetch PC (RESET_PC out of reset).
  assign o_inst    = w_empty ? NOP_INST : w_head.inst;
  assign o_pc      = w_empty ? r_pc     : w_head.pc;
  assign o_imm_sel = imm_sel_f(o_inst[6:0]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc   <= RESET_PC;
      r_out  <= '0;
      r_drop <= '0;
    end else begin
      r_out <= r_out + CNT_W'(w_fire) - CNT_W'(i_imem_rvalid);
      if (i_redirect) begin
        r_pc   <= i_redirect_pc & ~32'h3;
        // Everything still outstanding is stale; a response landing now is
        // already discarded, so it does not need a drop credit.
        r_drop <= r_out - CNT_W'(i_imem_rvalid);
      end else begin
        if (w_fire) r_pc <= r_pc + 32'd4;
        if (i_imem_rvalid && r_drop != '0) r_drop <= r_drop - CNT_W'(1);
      end
    end
  end

  // PCs of in-flight requests; responses are in order, so every response
  // (kept or dropped) retires the oldest entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_if_wr <= '0;
      r_if_rd <= '0;
    end else begin
      if (w_fire)        r_if_wr <= (r_if_wr == LAST) ? '0 : r_if_wr + PTR_W'(1);
      if (i_imem_rvalid) r_if_rd <= (r_if_rd == LAST) ? '0 : r_if_rd + PTR_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_fire) r_ifpc[r_if_wr] <= r_pc;
  end

  a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(w_push && w_full));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        req, gnt, rvalid, redirect, valid, ready;
  logic [31:0] addr, rdata, redirect_pc, inst, pc;
  logic [1:0]  imm_sel;

  // second instance, RESET_PC near the top of the address space
  logic        req_w, rvalid_w, valid_w, redirect_w, ready_w;
  logic [31:0] addr_w, rdata_w, rpc_w, inst_w, pc_w;
  logic [1:0]  sel_w;

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt),
    .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_inst_valid(valid), .i_dec_ready(ready),
    .o_inst(inst), .o_pc(pc), .o_imm_sel(imm_sel)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(req_w), .o_imem_addr(addr_w), .i_imem_gnt(gnt),
    .i_imem_rvalid(rvalid_w), .i_imem_rdata(rdata_w),
    .i_redirect(redirect_w), .i_redirect_pc(rpc_w),
    .o_inst_valid(valid_w), .i_dec_ready(ready_w),
    .o_inst(inst_w), .o_pc(pc_w), .o_imm_sel(sel_w)
  );

  // 1-cycle memory for the second instance
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rvalid_w <= 1'b0;
    else        rvalid_w <= req_w & gnt;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] addr; int epoch; int due; } pend_t;
  pend_t       pend[$];     // granted requests awaiting response, in order
  logic [31:0] mq[$];       // PCs of instructions visible to decode
  int          epoch, cyc, first_valid, npop, nreq;
  logic [31:0] exp_addr;
  logic [31:0] wlog[3];
  int          wlog_n;
  // stimulus knobs
  bit          s_redir, s_ready, hold;
  logic [31:0] s_tgt;
  int          gnt_pct, lat_max;
  // first-event capture after a marker
  bit          cap_on;
  logic [31:0] cap_addr, cap_pc;
  bit          cap_addr_ok, cap_pc_ok;

  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [6:0] op;
    if (a == 32'h200) return 32'h00A12223;
    if (a == 32'h204) return 32'h00208463;
    if (a == 32'h208) return 32'h00500093;
    case (a[4:2])
      3'd0: op = OP_STORE;   3'd1: op = OP_BRANCH;
      3'd2: op = 7'h13;      3'd3: op = 7'h33;
      3'd4: op = 7'h03;      3'd5: op = 7'h6F;
      3'd6: op = OP_STORE;   default: op = 7'h37;
    endcase
    return {a[31:7] ^ 25'h1A5A5A5, op};
  endfunction

  function automatic logic [1:0] ref_sel(input logic [31:0] i);
    if (i[6:0] == 7'b0100011) return 2'b01;
    if (i[6:0] == 7'b1100011) return 2'b10;
    return 2'b00;
  endfunction

  task automatic step();
    bit e_req, e_valid, e_pop, rv;
    logic [31:0] e_inst;
    pend_t p;
    @(posedge clk); #1;
    redirect    = s_redir;
    redirect_pc = s_tgt;
    ready       = s_ready;
    gnt         = ($urandom_range(99) < gnt_pct);
    rv          = !hold && pend.size() > 0 && pend[0].due <= cyc;
    rvalid      = rv;
    rdata       = rv ? memf(pend[0].addr) : $urandom;
    #1;
    e_valid = mq.size() > 0 && !s_redir;
    e_pop   = e_valid && s_ready;
    e_req   = !s_redir && (pend.size() + mq.size() - (e_pop ? 1 : 0) < 2);
    e_inst  = mq.size() > 0 ? memf(mq[0]) : NOP_INST;
    chk("req", req, e_req);
    if (e_req) chk("addr", addr, exp_addr);
    chk("valid", valid, e_valid);
    chk("inst", inst, e_inst);
    if (mq.size() > 0) chk("pc", pc, mq[0]);
    chk("imm_sel", imm_sel, ref_sel(e_inst));
    if (e_valid && first_valid < 0) first_valid = cyc;
    if (e_pop) npop++;
    if (e_req) nreq++;
    if (cap_on && !cap_addr_ok && e_req && gnt) begin cap_addr = addr; cap_addr_ok = 1; end
    if (cap_on && !cap_pc_ok && e_valid) begin cap_pc = pc; cap_pc_ok = 1; end
    if (wlog_n < 3 && req_w && gnt) begin wlog[wlog_n] = addr_w; wlog_n++; end
    // advance model state across the coming edge
    if (e_pop) void'(mq.pop_front());
    if (rv) begin
      p = pend.pop_front();
      if (p.epoch == epoch && !s_redir) mq.push_back(p.addr);
    end
    if (s_redir) begin
      mq.delete();
      epoch++;
      exp_addr = s_tgt & ~32'h3;
    end else if (e_req && gnt) begin
      pend.push_back('{exp_addr, epoch, cyc + 1 + (lat_max > 0 ? int'($urandom_range(lat_max)) : 0)});
      exp_addr += 4;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 0; redirect_pc = 0; gnt = 0; rvalid = 0; rdata = 0; ready = 0;
    s_redir = 0; s_tgt = 0; s_ready = 0; hold = 0; gnt_pct = 100; lat_max = 0;
    pend.delete(); mq.delete();
    exp_addr = 0; cyc = 0; first_valid = -1; npop = 0; nreq = 0; wlog_n = 0;
    cap_on = 0; cap_addr_ok = 0; cap_pc_ok = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", req, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_inst", inst, 32'h13);
    chk("rst_pc", pc, 32'h0);
    chk("rst_sel", imm_sel, 2'b00);
    rst_n = 1'b1;   // gnt=0 for the rest of this cycle, so cycle 0 is next
  endtask

  initial begin
    redirect_w = 0; rpc_w = 0; rdata_w = NOP_INST; ready_w = 1;

    // streaming from reset, 1-cycle memory
    do_reset();
    s_ready = 1;
    repeat (10) step();
    chk("t1_first_valid", first_valid, 2);
    chk("t1_reqs", nreq, 10);
    chk("t1_pops", npop, 8);
    chk("wrap_n", wlog_n, 3);
    chk("wrap_a0", wlog[0], 32'hFFFF_FFF8);
    chk("wrap_a1", wlog[1], 32'hFFFF_FFFC);
    chk("wrap_a2", wlog[2], 32'h0000_0000);

    // redirect while a response lands and decode is ready
    s_redir = 1; s_tgt = 32'h202;
    step();
    chk("t4_valid_on_redir", valid, 1'b0);
    s_redir = 0;
    repeat (3) step();
    chk("t5_sw_pc", pc, 32'h200);
    chk("t5_sw_sel", imm_sel, 2'b01);
    step();
    chk("t5_beq_sel", imm_sel, 2'b10);
    step();
    chk("t5_addi_sel", imm_sel, 2'b00);
    gnt_pct = 0;
    repeat (4) step();
    chk("t5_empty_inst", inst, 32'h13);
    chk("t5_empty_sel", imm_sel, 2'b00);

    // backpressure
    do_reset();
    s_ready = 0;
    repeat (5) step();
    chk("t2_reqs", nreq, 2);
    chk("t2_head_pc", pc, 32'h0);
    chk("t2_req_stalled", req, 1'b0);
    s_ready = 1;
    repeat (6) step();
    chk("t2_pops", npop, 6);

    // redirect with two responses in flight
    do_reset();
    s_ready = 1; hold = 1;
    repeat (2) step();
    s_redir = 1; s_tgt = 32'h103;
    step();
    s_redir = 0; hold = 0; cap_on = 1;
    repeat (8) step();
    chk("t3_addr_ok", cap_addr_ok, 1'b1);
    chk("t3_first_addr", cap_addr, 32'h100);
    chk("t3_pc_ok", cap_pc_ok, 1'b1);
    chk("t3_first_pc", cap_pc, 32'h100);

    // randomized traffic
    do_reset();
    gnt_pct = 70; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      s_ready = ($urandom_range(99) < 75);
      s_redir = ($urandom_range(99) < 4);
      s_tgt   = $urandom;
      step();
    end
    chk("rand_pops_nonzero", (npop > 100), 1'b1);

    // asynchronous reset mid-stream
    s_redir = 0; s_ready = 0; gnt_pct = 100; lat_max = 0;
    repeat (4) step();
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", valid, 1'b0);
    chk("async_rst_req", req, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
